// File: rtl/fpu_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_div_iter
// Brief    : Iterative IEEE-754-style floating-point divider. Uses a restoring
//            radix-2 divider that produces one quotient bit per cycle. Rounds
//            to nearest, ties to even. Subnormal inputs are treated as zero
//            (DAZ) and subnormal results are flushed to zero (FTZ).
// Revision : 1.0 - initial release
// ============================================================================
module fpu_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   f1,
  input  logic [EXP_W+MAN_W:0]   f2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [4:0]             flags
);

  localparam int c_w  = 1 + EXP_W + MAN_W;
  localparam int c_ew = EXP_W + 2;
  localparam int c_cw = $clog2(MAN_W + 3);

  localparam logic [EXP_W-1:0]        c_exp_ones = '1;
  localparam logic signed [c_ew-1:0]  c_bias     = c_ew'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [c_ew-1:0]  c_emax     = c_ew'((1 << EXP_W) - 1);
  localparam logic signed [c_ew-1:0]  c_one      = c_ew'(1);
  localparam logic signed [c_ew-1:0]  c_zero     = '0;
  localparam logic [c_cw-1:0]         c_cnt_init = c_cw'(MAN_W + 2);
  localparam logic [c_cw-1:0]         c_cnt_one  = c_cw'(1);
  localparam logic [c_w-1:0]          c_nan      = {1'b0, {(c_w-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIVIDE = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [c_w-1:0]         r_f1;
  logic [c_w-1:0]         r_f2;
  logic                   r_sign;
  logic signed [c_ew-1:0] r_exp;
  logic [MAN_W+1:0]       r_rem;
  logic [MAN_W:0]         r_div;
  logic [MAN_W+2:0]       r_quo;
  logic [c_cw-1:0]        r_cnt;
  logic [c_w-1:0]         r_result;
  logic [4:0]             r_flags;

  // --------------------------------------------------------------------------
  // Operand fields and classification (evaluated while in UNPACK)
  // --------------------------------------------------------------------------
  logic [EXP_W-1:0]       w_ex1;
  logic [EXP_W-1:0]       w_ex2;
  logic [MAN_W-1:0]       w_m1;
  logic [MAN_W-1:0]       w_m2;
  logic                   w_sign;
  logic                   w_nan1;
  logic                   w_nan2;
  logic                   w_inf1;
  logic                   w_inf2;
  logic                   w_zero1;
  logic                   w_zero2;
  logic signed [c_ew-1:0] w_exp;
  logic [c_w-1:0]         w_inf_res;
  logic [c_w-1:0]         w_zero_res;

  assign w_ex1   = r_f1[c_w-2:MAN_W];
  assign w_ex2   = r_f2[c_w-2:MAN_W];
  assign w_m1    = r_f1[MAN_W-1:0];
  assign w_m2    = r_f2[MAN_W-1:0];
  assign w_sign  = r_f1[c_w-1] ^ r_f2[c_w-1];
  assign w_nan1  = (w_ex1 == c_exp_ones) && (w_m1 != '0);
  assign w_nan2  = (w_ex2 == c_exp_ones) && (w_m2 != '0);
  assign w_inf1  = (w_ex1 == c_exp_ones) && (w_m1 == '0);
  assign w_inf2  = (w_ex2 == c_exp_ones) && (w_m2 == '0);
  // A zero exponent field covers both true zeros and subnormals (DAZ).
  assign w_zero1 = (w_ex1 == '0);
  assign w_zero2 = (w_ex2 == '0);
  // Two guard bits keep the biased difference signed and overflow-free.
  assign w_exp   = {2'b00, w_ex1} - {2'b00, w_ex2} + c_bias;

  assign w_inf_res  = {w_sign, c_exp_ones, {MAN_W{1'b0}}};
  assign w_zero_res = {w_sign, {(c_w-1){1'b0}}};

  logic           w_special;
  logic [c_w-1:0] w_spec_res;
  logic [4:0]     w_spec_flg;

  // Special-operand result selection; priority order matters (NaN first, then invalid).
  always_comb begin
    w_special  = 1'b1;
    w_spec_res = w_zero_res;
    w_spec_flg = 5'b00000;
    if (w_nan1 || w_nan2) begin
      w_spec_res = c_nan;
    end else if ((w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
      w_spec_res = c_nan;
      w_spec_flg = 5'b10000;
    end else if (w_inf1) begin
      w_spec_res = w_inf_res;
    end else if (w_zero2) begin
      w_spec_res = w_inf_res;
      w_spec_flg = 5'b01000;
    end else if (w_inf2 || w_zero1) begin
      w_spec_res = w_zero_res;
    end else begin
      w_special  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Restoring divide step
  // --------------------------------------------------------------------------
  logic [MAN_W+1:0] w_div_ext;
  logic             w_ge;
  logic [MAN_W+1:0] w_diff;

  assign w_div_ext = {1'b0, r_div};
  assign w_ge      = (r_rem >= w_div_ext);
  assign w_diff    = w_ge ? (r_rem - w_div_ext) : r_rem;

  // --------------------------------------------------------------------------
  // Normalise and round (evaluated while in ROUND)
  // --------------------------------------------------------------------------
  logic                   w_int;
  logic [MAN_W:0]         w_norm_man;
  logic                   w_guard;
  logic                   w_sticky;
  logic signed [c_ew-1:0] w_e_norm;
  logic                   w_rup;
  logic [MAN_W+1:0]       w_sum;
  logic                   w_carry;
  logic [MAN_W-1:0]       w_frac;
  logic signed [c_ew-1:0] w_e_fin;
  logic [c_w-1:0]         w_rnd_res;
  logic [4:0]             w_rnd_flg;

  // The quotient lies in (0.5, 2); a clear integer bit means one extra shift.
  assign w_int      = r_quo[MAN_W+2];
  assign w_norm_man = w_int ? r_quo[MAN_W+2:2] : r_quo[MAN_W+1:1];
  assign w_guard    = w_int ? r_quo[1] : r_quo[0];
  assign w_sticky   = (w_int & r_quo[0]) | (r_rem != '0);
  assign w_e_norm   = w_int ? r_exp : (r_exp - c_one);
  assign w_rup      = w_guard & (w_sticky | w_norm_man[0]);
  assign w_sum      = {1'b0, w_norm_man} + {{(MAN_W+1){1'b0}}, w_rup};
  assign w_carry    = w_sum[MAN_W+1];
  // On carry-out the mantissa is exactly 10...0, so the stored fraction is zero.
  assign w_frac     = w_carry ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
  assign w_e_fin    = w_e_norm + (w_carry ? c_one : c_zero);

  // Final exponent range check selects overflow, flush-to-zero or normal result.
  always_comb begin
    w_rnd_res = {r_sign, w_e_fin[EXP_W-1:0], w_frac};
    w_rnd_flg = {4'b0000, w_guard | w_sticky};
    if (w_e_fin >= c_emax) begin
      w_rnd_res = {r_sign, c_exp_ones, {MAN_W{1'b0}}};
      w_rnd_flg = 5'b00101;
    end else if (w_e_fin <= c_zero) begin
      w_rnd_res = {r_sign, {(c_w-1){1'b0}}};
      w_rnd_flg = 5'b00011;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = UNPACK;
      UNPACK:  w_next = w_special ? DONE : DIVIDE;
      DIVIDE:  if (r_cnt == '0) w_next = ROUND;
      ROUND:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign flags     = r_flags;

  // Datapath: operand capture, unpack, iterate and final result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f1     <= '0;
      r_f2     <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_f1 <= f1;
            r_f2 <= f2;
          end
        end
        UNPACK: begin
          r_sign <= w_sign;
          r_exp  <= w_exp;
          r_rem  <= {1'b0, 1'b1, w_m1};
          r_div  <= {1'b1, w_m2};
          r_quo  <= '0;
          r_cnt  <= c_cnt_init;
          if (w_special) begin
            r_result <= w_spec_res;
            r_flags  <= w_spec_flg;
          end
        end
        DIVIDE: begin
          r_rem <= w_diff << 1;
          r_quo <= {r_quo[MAN_W+1:0], w_ge};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        ROUND: begin
          r_result <= w_rnd_res;
          r_flags  <= w_rnd_flg;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fpu_div_iter.md
FPU_DIV_ITER -- requirements
Module: fpu_div_iter

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (>=4).
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width (>=4); W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  divider idle, can accept operands.
REQ-007 SHALL have port f1  input  W  dividend, IEEE-754-style {sign, exp, man}.
REQ-008 SHALL have port f2  input  W  divisor, same format.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  W  quotient f1/f2.
REQ-012 SHALL have port flags  output  5  {invalid, div_by_zero, overflow, underflow, inexact}.

Function
REQ-013 SHALL use FSM states IDLE, UNPACK, DIVIDE, ROUND, DONE; in_ready = (state==IDLE).
REQ-014 Accept SHALL occur on an edge with in_valid && in_ready: f1, f2 registered, IDLE->UNPACK.
REQ-015 UNPACK SHALL classify operands, compute sign = f1[W-1]^f2[W-1], and compute signed exponent e = ex1-ex2+bias in EXP_W+2 bits; special cases go to DONE, others to DIVIDE.
REQ-016 Subnormal inputs SHALL be treated as signed zero (DAZ).
REQ-017 Special results SHALL be: any NaN -> canonical NaN {0, all-ones exp, all-ones man}; 0/0 or inf/inf -> NaN + invalid; finite nonzero/0 -> signed inf + div_by_zero; inf/finite -> signed inf; finite/inf and 0/finite nonzero -> signed zero; no other flags set.
REQ-018 DIVIDE SHALL be restoring radix-2, one quotient bit per cycle, exactly MAN_W+3 cycles; dividend and divisor have the hidden 1 prepended; iteration counter counts down to 0.
REQ-019 ROUND SHALL normalise (if quotient integer bit is 0: shift left 1, e-1); guard = next bit; sticky = OR of remaining bits and (remainder != 0); round to nearest, ties to even; mantissa carry-out SHALL increment e.
REQ-020 If e >= 2^EXP_W-1 after rounding: result = signed inf, overflow=1, inexact=1.
REQ-021 If e <= 0: result = signed zero (FTZ), underflow=1, inexact=1.
REQ-022 Otherwise inexact = guard|sticky, remaining flags 0.
REQ-023 Latency from accepting edge to out_valid high SHALL be MAN_W+5 edges for regular operands (28 at defaults) and 1 edge for special cases.
REQ-024 DONE SHALL hold out_valid, result and flags stable until out_valid && out_ready; that edge returns to IDLE (new accept possible the following edge; no overlap).
REQ-025 in_valid while busy SHALL be ignored; f1/f2 changes after accept SHALL not affect the result.
REQ-026 result and flags SHALL be registered outputs; no combinational path from inputs to outputs.

Reset
REQ-027 rst high SHALL immediately force state IDLE, out_valid=0, result=0, flags=0, counter=0; in_ready=1 from release.
REQ-028 rst asserted mid-operation SHALL abort it silently; no result for that operation is ever produced.

Verification (defaults unless stated)
REQ-029 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000, flags 0, out_valid exactly 28 edges after accept.
REQ-030 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, inexact=1; 0xC0C00000 / 0x40000000 -> 0xC0400000, flags 0.
REQ-031 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1, 1-edge latency; 0x00000000 / 0x00000000 -> 0x7FFFFFFF, invalid=1; 0x7F800000 / 0x7F800000 -> 0x7FFFFFFF, invalid=1.
REQ-032 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, overflow=1, inexact=1; 0x00800000 / 0x40000000 -> 0x00000000, underflow=1, inexact=1.
REQ-033 out_ready low 5 cycles after out_valid -> result/flags stable, in_ready=0, extra in_valid ignored; rst pulse in DIVIDE -> out_valid=0 immediately, in_ready=1 after release, next op correct.
REQ-034 EXP_W=5, MAN_W=10: 0x4600 / 0x4000 -> 0x4200, flags 0, latency 15 edges.
